// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Register map, bit positions and CTRL layout for uart_host_if.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam logic [1:0] UART_DATA   = 2'd0;
    localparam logic [1:0] UART_CTRL   = 2'd1;
    localparam logic [1:0] UART_STATUS = 2'd2;
    localparam logic [1:0] UART_BAUD   = 2'd3;

    localparam int CTRL_UART_EN       = 0;
    localparam int CTRL_TX_EN         = 1;
    localparam int CTRL_RX_EN         = 2;
    localparam int CTRL_PARITY_ENABLE = 3;
    localparam int CTRL_PARITY        = 4;
    localparam int CTRL_STOP_BIT      = 5;

    localparam int STAT_TX_EMPTY  = 0;
    localparam int STAT_TX_FULL   = 1;
    localparam int STAT_RX_EMPTY  = 2;
    localparam int STAT_RX_FULL   = 3;
    localparam int STAT_TX_OVF    = 4;
    localparam int STAT_RX_OVR    = 5;
    localparam int STAT_PAR_ERR   = 6;
    localparam int STAT_FRM_ERR   = 7;
    localparam int STAT_BUSY      = 8;
    localparam int STAT_CNT_LSB   = 12;

    // Field order puts uart_en at bit 0 so the struct maps directly onto CTRL[5:0].
    typedef struct packed {
        logic stop_bit;
        logic parity;
        logic parity_enable;
        logic rx_en;
        logic tx_en;
        logic uart_en;
    } uart_ctrl_t;

    function automatic logic [3:0] sat_count4(input logic [31:0] cnt);
        return (cnt > 32'd15) ? 4'd15 : cnt[3:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_sync_fifo
// Description : Single-clock FIFO with extra-MSB pointers and combinational head.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wptr;
    logic [c_AW:0]    r_rptr;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign empty = (r_wptr == r_rptr);
    assign full  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                   (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
    assign count = r_wptr - r_rptr;

    // A pop frees the slot a same-cycle push needs, so a full FIFO accepts both.
    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || w_pop_ok);

    assign dout = empty ? '0 : r_mem[r_rptr[c_AW-1:0]];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + (c_AW+1)'(1);
            if (w_pop_ok)  r_rptr <= r_rptr + (c_AW+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (w_push_ok) r_mem[r_wptr[c_AW-1:0]] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/uart_host_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_host_if
// Description : Host register file and TX/RX buffering in front of the UART core.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_host_if
    import uart_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        uart_en,
    output logic        tx_en,
    output logic        rx_en,
    output logic        parity_enable,
    output logic        parity,
    output logic        stop_bit,
    output logic [15:0] baud_div,
    input  logic        tx_fifo_rd_en,
    output logic [7:0]  tx_data,
    output logic        tx_fifo_empty,
    input  logic        rx_fifo_wr_en,
    input  logic [7:0]  rx_data,
    input  logic        receive_parity,
    output logic        rx_fifo_full,
    input  logic        status_reg_en,
    input  logic        stop_bit_error,
    input  logic        busy
);

    localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;

    uart_ctrl_t         r_ctrl;
    logic [15:0]        r_baud;
    logic [3:0]         r_sticky;
    logic [31:0]        r_rdata;

    logic               w_host_rd;
    logic               w_tx_push;
    logic               w_tx_full;
    logic               w_rx_pop;
    logic               w_rx_empty;
    logic [7:0]         w_rx_head;
    logic [c_CNT_W-1:0] w_tx_count;
    logic [c_CNT_W-1:0] w_rx_count;
    logic [3:0]         w_set;
    logic [3:0]         w_clr;
    logic [31:0]        w_status;
    logic [31:0]        w_rdata_next;
    logic               w_unused;

    // A write strobe always wins over a simultaneous read strobe.
    assign w_host_rd = rd_en && !wr_en;
    assign w_tx_push = wr_en && (addr == UART_DATA);
    assign w_rx_pop  = w_host_rd && (addr == UART_DATA);

    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (w_tx_push),
        .pop   (tx_fifo_rd_en),
        .din   (wdata[7:0]),
        .dout  (tx_data),
        .full  (w_tx_full),
        .empty (tx_fifo_empty),
        .count (w_tx_count)
    );

    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (rx_fifo_wr_en),
        .pop   (w_rx_pop),
        .din   (rx_data),
        .dout  (w_rx_head),
        .full  (rx_fifo_full),
        .empty (w_rx_empty),
        .count (w_rx_count)
    );

    // A full FIFO is never empty, so a concurrent pop always makes room.
    assign w_set[0] = w_tx_push && w_tx_full && !tx_fifo_rd_en;
    assign w_set[1] = rx_fifo_wr_en && rx_fifo_full && !w_rx_pop;
    assign w_set[2] = rx_fifo_wr_en && r_ctrl.parity_enable &&
                      (receive_parity != ((^rx_data) ^ r_ctrl.parity));
    assign w_set[3] = status_reg_en && stop_bit_error;
    assign w_clr    = (wr_en && (addr == UART_STATUS)) ? wdata[7:4] : 4'b0000;

    assign w_status = {16'h0000, sat_count4(32'(w_rx_count)), 3'b000, busy,
                       r_sticky, rx_fifo_full, w_rx_empty, w_tx_full, tx_fifo_empty};

    always_comb begin
        w_rdata_next = r_rdata;
        if (w_host_rd) begin
            case (addr)
                UART_DATA:   w_rdata_next = {24'h000000, w_rx_head};
                UART_CTRL:   w_rdata_next = {26'h0, r_ctrl};
                UART_STATUS: w_rdata_next = w_status;
                UART_BAUD:   w_rdata_next = {16'h0000, r_baud};
                default:     w_rdata_next = r_rdata;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ctrl   <= '0;
            r_baud   <= DIV_RESET;
            r_sticky <= '0;
            r_rdata  <= '0;
        end else begin
            r_rdata  <= w_rdata_next;
            r_sticky <= (r_sticky & ~w_clr) | w_set;
            if (wr_en && (addr == UART_CTRL))
                r_ctrl <= uart_ctrl_t'(wdata[5:0]);
            // A zero divisor would stall the baud generator, so clamp it to 1.
            if (wr_en && (addr == UART_BAUD))
                r_baud <= (wdata[15:0] == 16'd0) ? 16'd1 : wdata[15:0];
        end
    end

    assign rdata         = r_rdata;
    assign uart_en       = r_ctrl.uart_en;
    assign tx_en         = r_ctrl.tx_en;
    assign rx_en         = r_ctrl.rx_en;
    assign parity_enable = r_ctrl.parity_enable;
    assign parity        = r_ctrl.parity;
    assign stop_bit      = r_ctrl.stop_bit;
    assign baud_div      = r_baud;

    assign w_unused = &{1'b0, wdata[31:16], w_tx_count};

endmodule
`default_nettype wire

// File: tb/tb_uart_host_if.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_host_if
// Description : Directed and random checks of uart_host_if against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_host_if;

    localparam int          DEPTH = 8;
    localparam logic [15:0] DIV   = 16'd434;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  addr = 2'd0;
    logic        wr_en = 1'b0, rd_en = 1'b0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        uart_en, tx_en, rx_en, parity_enable, parity, stop_bit;
    logic [15:0] baud_div;
    logic        tx_fifo_rd_en = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_fifo_empty;
    logic        rx_fifo_wr_en = 1'b0;
    logic [7:0]  rx_data = 8'h0;
    logic        receive_parity = 1'b0;
    logic        rx_fifo_full;
    logic        status_reg_en = 1'b0, stop_bit_error = 1'b0, busy = 1'b0;

    uart_host_if #(.FIFO_DEPTH(DEPTH), .DIV_RESET(DIV)) dut (
        .clock(clock), .reset(reset), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
        .wdata(wdata), .rdata(rdata), .uart_en(uart_en), .tx_en(tx_en), .rx_en(rx_en),
        .parity_enable(parity_enable), .parity(parity), .stop_bit(stop_bit),
        .baud_div(baud_div), .tx_fifo_rd_en(tx_fifo_rd_en), .tx_data(tx_data),
        .tx_fifo_empty(tx_fifo_empty), .rx_fifo_wr_en(rx_fifo_wr_en), .rx_data(rx_data),
        .receive_parity(receive_parity), .rx_fifo_full(rx_fifo_full),
        .status_reg_en(status_reg_en), .stop_bit_error(stop_bit_error), .busy(busy)
    );

    always #5 clock = ~clock;

    // Reference state: byte queues for the FIFOs plus the architectural registers.
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];
    logic [5:0]  m_ctrl;
    logic [15:0] m_baud;
    logic [3:0]  m_sticky;
    logic [31:0] m_rdata;
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic logic [31:0] m_status();
        int c;
        c = (rx_q.size() > 15) ? 15 : rx_q.size();
        return {16'h0, c[3:0], 3'b000, busy, m_sticky,
                rx_q.size() == DEPTH, rx_q.size() == 0,
                tx_q.size() == DEPTH, tx_q.size() == 0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [3:0] set_b;
        logic [3:0] clr_b;
        if (reset) begin
            tx_q.delete(); rx_q.delete();
            m_ctrl = '0; m_baud = DIV; m_sticky = '0; m_rdata = '0;
        end else begin
            set_b = '0; clr_b = '0;
            if (rd_en && !wr_en) begin
                case (addr)
                    2'd0: m_rdata = (rx_q.size() > 0) ? {24'h0, rx_q[0]} : 32'h0;
                    2'd1: m_rdata = {26'h0, m_ctrl};
                    2'd2: m_rdata = m_status();
                    default: m_rdata = {16'h0, m_baud};
                endcase
            end
            if (tx_fifo_rd_en && tx_q.size() > 0) void'(tx_q.pop_front());
            if (wr_en && addr == 2'd0) begin
                if (tx_q.size() < DEPTH) tx_q.push_back(wdata[7:0]);
                else set_b[0] = 1'b1;
            end
            if (rd_en && !wr_en && addr == 2'd0 && rx_q.size() > 0) void'(rx_q.pop_front());
            if (rx_fifo_wr_en) begin
                if (rx_q.size() < DEPTH) rx_q.push_back(rx_data);
                else set_b[1] = 1'b1;
                if (m_ctrl[3] && receive_parity != ((^rx_data) ^ m_ctrl[4])) set_b[2] = 1'b1;
            end
            if (status_reg_en && stop_bit_error) set_b[3] = 1'b1;
            if (wr_en && addr == 2'd2) clr_b = wdata[7:4];
            m_sticky = (m_sticky & ~clr_b) | set_b;
            if (wr_en && addr == 2'd1) m_ctrl = wdata[5:0];
            if (wr_en && addr == 2'd3) m_baud = (wdata[15:0] == 0) ? 16'd1 : wdata[15:0];
        end
        @(posedge clock);
        #1;
        check("rdata", rdata, m_rdata);
        check("tx_fifo_empty", tx_fifo_empty, tx_q.size() == 0);
        check("rx_fifo_full", rx_fifo_full, rx_q.size() == DEPTH);
        check("tx_data", tx_data, (tx_q.size() > 0) ? tx_q[0] : 8'h00);
        check("ctrl_out", {stop_bit, parity, parity_enable, rx_en, tx_en, uart_en}, m_ctrl);
        check("baud_div", baud_div, m_baud);
    endtask

    task automatic host_wr(input logic [1:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr_en = 1'b1; step(); wr_en = 1'b0;
    endtask

    task automatic host_rd(input logic [1:0] a);
        addr = a; rd_en = 1'b1; step(); rd_en = 1'b0;
    endtask

    task automatic rx_push(input logic [7:0] d, input logic p);
        rx_data = d; receive_parity = p; rx_fifo_wr_en = 1'b1; step(); rx_fifo_wr_en = 1'b0;
    endtask

    task automatic tx_pop();
        tx_fifo_rd_en = 1'b1; step(); tx_fifo_rd_en = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        step(); step();
        reset = 1'b0;

        host_rd(2'd2);  check("reset_status", rdata, 32'h5);
        host_rd(2'd3);  check("reset_baud", rdata, 32'd434);

        for (int i = 0; i < 9; i++) host_wr(2'd0, 32'hA0 + i);
        check("tx_not_empty", tx_fifo_empty, 1'b0);
        host_rd(2'd2);
        check("stat_tx_full", rdata[1], 1'b1);
        check("stat_tx_ovf", rdata[4], 1'b1);
        for (int i = 0; i < 8; i++) begin
            check("tx_head_order", tx_data, 8'hA0 + i);
            tx_pop();
        end
        check("tx_drained", tx_fifo_empty, 1'b1);

        host_wr(2'd1, 32'h3F);
        rx_push(8'h55, 1'b1);
        host_rd(2'd2);  check("parity_ok", rdata[6], 1'b0);
        rx_push(8'h55, 1'b0);
        host_rd(2'd2);  check("parity_err", rdata[6], 1'b1);
        host_wr(2'd2, 32'h40);
        host_rd(2'd2);  check("parity_w1c", rdata[6], 1'b0);
        host_rd(2'd0);  host_rd(2'd0);

        for (int i = 0; i < 8; i++) begin
            b = 8'h10 + 8'(i);
            rx_push(b, (^b) ^ 1'b1);
        end
        rx_push(8'hEE, 1'b0);
        check("rx_full", rx_fifo_full, 1'b1);
        host_rd(2'd2);
        check("rx_overrun", rdata[5], 1'b1);
        check("rx_count", rdata[15:12], 4'd8);
        for (int i = 0; i < 8; i++) begin
            host_rd(2'd0);
            check("rx_order", rdata, 32'h10 + i);
        end
        host_rd(2'd0);  check("rx_empty_read", rdata, 32'h0);

        host_wr(2'd2, 32'hF0);
        for (int i = 0; i < 8; i++) host_wr(2'd0, 32'hB0 + i);
        tx_fifo_rd_en = 1'b1;
        host_wr(2'd0, 32'hC5);
        tx_fifo_rd_en = 1'b0;
        host_rd(2'd2);
        check("push_pop_no_ovf", rdata[4], 1'b0);
        check("push_pop_full", rdata[1], 1'b1);
        for (int i = 0; i < 7; i++) tx_pop();
        check("push_pop_last", tx_data, 8'hC5);
        tx_pop();

        status_reg_en = 1'b1; stop_bit_error = 1'b1; step();
        status_reg_en = 1'b0; stop_bit_error = 1'b0;
        host_rd(2'd2);  check("frame_err", rdata[7], 1'b1);
        host_wr(2'd3, 32'h0);
        host_rd(2'd3);  check("baud_zero", rdata, 32'h1);

        for (int i = 0; i < 4; i++) begin
            host_wr(2'd0, 32'h60 + i);
            rx_push(8'h70 + 8'(i), 1'b0);
        end
        reset = 1'b1; step(); reset = 1'b0;
        check("rst_tx_empty", tx_fifo_empty, 1'b1);
        check("rst_rx_full", rx_fifo_full, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_baud", baud_div, 16'd434);
        host_rd(2'd2);  check("rst_status", rdata, 32'h5);

        for (int n = 0; n < 1500; n++) begin
            int op;
            op = $urandom_range(0, 9);
            busy           = 1'($urandom);
            tx_fifo_rd_en  = ($urandom_range(0, 2) == 0);
            rx_fifo_wr_en  = ($urandom_range(0, 2) == 0);
            rx_data        = 8'($urandom);
            receive_parity = 1'($urandom);
            status_reg_en  = ($urandom_range(0, 7) == 0);
            stop_bit_error = 1'($urandom);
            addr           = 2'($urandom);
            wdata          = $urandom;
            if (addr == 2'd3 && $urandom_range(0, 3) == 0) wdata = 32'h0;
            wr_en = (op < 3);
            rd_en = (op >= 3 && op < 7);
            if (rd_en && $urandom_range(0, 1) == 0) addr = 2'd0;
            step();
        end
        wr_en = 1'b0; rd_en = 1'b0; tx_fifo_rd_en = 1'b0; rx_fifo_wr_en = 1'b0;
        status_reg_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_host_if.md
# uart_host_if

Host-facing register and buffering end of the UART. It sits between the processor bus and the UART controller/datapath. The host writes bytes into a TX FIFO, which the controller drains with `tx_fifo_rd_en`. The controller fills an RX FIFO with `rx_fifo_wr_en`, and the host drains it through the data register. The block also holds the control, baud-divisor and sticky-status registers that configure and report on the controller.

## Interface
Parameters:
- `FIFO_DEPTH`, 8 — entries per FIFO; power of two, ≥2.
- `DIV_RESET`, 16'd434 — baud divisor reset value.

Ports (one clock; reset is synchronous and active-high):
- `clock` in 1 — sole clock.
- `reset` in 1 — synchronous, active-high.
- `addr` in 2 — word index: 0 DATA, 1 CTRL, 2 STATUS, 3 BAUD_DIV.
- `wr_en` in 1 — host write strobe, one cycle.
- `rd_en` in 1 — host read strobe, one cycle.
- `wdata` in 32 — host write data.
- `rdata` out 32 — registered read data.
- `uart_en`, `tx_en`, `rx_en`, `parity_enable`, `parity`, `stop_bit` out 1 each — CTRL[5:0] fields.
- `baud_div` out 16 — BAUD_DIV[15:0].
- `tx_fifo_rd_en` in 1 — controller pops TX head.
- `tx_data` out 8 — TX FIFO head, combinational.
- `tx_fifo_empty` out 1 — TX FIFO empty.
- `rx_fifo_wr_en` in 1 — controller pushes `rx_data`.
- `rx_data` in 8 — received byte.
- `receive_parity` in 1 — received parity bit, valid with `rx_fifo_wr_en`.
- `rx_fifo_full` out 1 — RX FIFO full.
- `status_reg_en` in 1 — frame complete; latch `stop_bit_error`.
- `stop_bit_error` in 1 — framing error, valid with `status_reg_en`.
- `busy` in 1 — controller busy, reported in STATUS.

## Operation
- DATA write pushes `wdata[7:0]` into the TX FIFO.
  - If the TX FIFO is full: data is dropped and sticky `tx_overflow` (STATUS[4]) is set.
- DATA read returns `{24'b0, rx_head}` and pops the RX FIFO.
  - If the RX FIFO is empty: returns 0, no pop, no error.
- CTRL read/write on bits [5:0]: `uart_en`, `tx_en`, `rx_en`, `parity_enable`, `parity` (1 = odd), `stop_bit` (1 = stop bit present). Upper bits read 0.
- BAUD_DIV read/write on [15:0].
  - A written value of 0 is stored as 1.
- STATUS bits:
  - [0] `tx_fifo_empty`, [1] TX full, [2] RX empty, [3] `rx_fifo_full` — live.
  - [4] `tx_overflow`, [5] `rx_overrun`, [6] `parity_error`, [7] `frame_error` — sticky.
  - [8] `busy` — live.
  - [15:12] RX occupancy count, saturating at 15.
  - Writing 1 to any of [7:4] clears that bit (W1C); other bits ignore writes.
- RX push:
  - When the RX FIFO is full, `rx_fifo_wr_en` drops the byte and sets `rx_overrun`.
  - Parity check when `parity_enable`: expected parity = `^rx_data ^ parity`. If `receive_parity` mismatches, `parity_error` is set at the push.
- `status_reg_en` with `stop_bit_error` = 1 sets `frame_error`.
- Each FIFO has read/write pointers of log2(`FIFO_DEPTH`)+1 bits.
  - Full: MSBs differ and the low bits are equal.
  - Empty: the pointers are equal.
  - Pointers wrap naturally.
- Host reads with no `rd_en` leave `rdata` holding its last value.

## Timing
- On reset:
  - `rdata` = 0; CTRL = 0 (all config outputs 0); `baud_div` = `DIV_RESET`; both FIFOs empty.
  - `tx_fifo_empty` = 1, `rx_fifo_full` = 0, sticky bits = 0, `tx_data` = 0.
  - Reset mid-transfer discards all FIFO contents in the same edge.
- Writes take effect at the edge where `wr_en` is sampled; config outputs change the following cycle.
- Reads: `rdata` is valid one cycle after `rd_en`. The RX pop happens at the same edge.
- `wr_en` and `rd_en` together: the write is performed and the read is ignored. Host contract: mutually exclusive.
- Simultaneous push and pop on one FIFO is allowed, occupancy unchanged:
  - Full FIFO: push and pop both succeed, no overflow.
  - Empty FIFO: the pop is ignored and the push succeeds.
- Sticky set and W1C clear in the same cycle: set wins.
- Flags and count reflect pointer state registered at the previous edge; no combinational path from `wr_en`/`rd_en` to `tx_fifo_empty`/`rx_fifo_full`.
- `tx_fifo_rd_en` while empty: ignored.

## Structure
- Package `uart_pkg`:
  - register index constants `UART_DATA`, `UART_CTRL`, `UART_STATUS`, `UART_BAUD`;
  - CTRL/STATUS bit-position constants;
  - `uart_ctrl_t` packed struct for CTRL.
- One sub-module `uart_sync_fifo` (params `WIDTH`, `DEPTH`): push/pop, `full`, `empty`, `count`, combinational head. Instantiated twice: TX and RX.
- Top level holds the address decode, CTRL/BAUD/sticky registers, parity checker and `rdata` register.

## Test plan
- Reset, then read STATUS → 0x0000_0005 (TX empty, RX empty); read BAUD_DIV → 434.
- 9 DATA writes (0xA0–0xA8), no TX pops → `tx_fifo_empty` = 0, TX full; STATUS[4] = 1; 8 pops yield A0…A7, then `tx_fifo_empty` = 1.
- CTRL = 0x3F; push `rx_data` = 0x55 with `receive_parity` = 1 (expected: `^0x55` = 0, ^odd = 1) → no parity error; push 0x55 with parity 0 → STATUS[6] = 1; write STATUS 0x40 → bit clears.
- Fill RX with 8 bytes, push a ninth → `rx_fifo_full` = 1, STATUS[5] = 1, count = 8; 8 DATA reads return the first 8 in order; a further read returns 0.
- With the TX FIFO full: `tx_fifo_rd_en` and a DATA write in the same cycle → no overflow, occupancy stays 8, new byte becomes last.
- `status_reg_en` with `stop_bit_error` = 1 → STATUS[7] = 1; write BAUD_DIV 0 → reads 1; assert `reset` with FIFOs half full → all flags back to reset values the next cycle.
